// File: rtl/shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Wide enough to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/N_ripple_adder.sv
// N-bit unsigned ripple-carry adder; sum[N] is the carry-out.
module N_ripple_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    logic [N:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_fa
        assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign sum[N] = carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN multiplier: one shared ripple adder, N shift-and-add
// steps per operation, valid/ready handshakes on operands and product.
module shift_add_multiplier
    import shift_add_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           done_valid,
    input  logic           done_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int CW = cnt_width(N);

    state_t           state_reg,   state_next;
    logic [N-1:0]     mcand_reg,   mcand_next;
    logic [N-1:0]     mplier_reg,  mplier_next;
    logic [N:0]       acc_reg,     acc_next;
    logic [CW-1:0]    cnt_reg,     cnt_next;
    logic [2*N-1:0]   product_reg, product_next;

    logic [N-1:0]     addend;
    logic [N:0]       sum;

    assign addend = mplier_reg[0] ? mcand_reg : '0;

    N_ripple_adder #(.N(N)) u_adder (
        .a   (acc_reg[N-1:0]),
        .b   (addend),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        case (state_reg)
            IDLE: begin
                if (start_valid) begin
                    mcand_next  = a_in;
                    mplier_next = b_in;
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                // Right-shift {sum, mplier}: the adder carry sum[N] lands in the
                // top of acc, sum[0] moves into the low partial product.
                acc_next    = {1'b0, sum[N:1]};
                mplier_next = {sum[0], mplier_reg[N-1:1]};
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == CW'(N - 1)) begin
                    product_next = {sum, mplier_reg[N-1:1]};
                    state_next   = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign start_ready = (state_reg == IDLE);
    assign done_valid  = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign product     = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed and random operations
// compared against a plain a*b reference with handshake and latency checks.
module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           done_ready = 1'b0;
    logic [N-1:0]   a_in = '0;
    logic [N-1:0]   b_in = '0;
    logic           start_ready;
    logic           done_valid;
    logic           busy;
    logic [2*N-1:0] product;

    int vectors = 0;
    int miscompares = 0;

    shift_add_multiplier #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .product     (product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, N RUN cycles with noise on the inputs,
    // hold DONE for 'hold' cycles, then handshake. If 'chain' is set the next
    // operands are presented with start_valid high while still in DONE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold,
                          input bit chain, input logic [N-1:0] na, input logic [N-1:0] nb);
        logic [2*N-1:0] exp;
        exp = (2*N)'(a) * (2*N)'(b);
        check("start_ready_idle", {15'b0, start_ready}, 1);
        start_valid = 1'b1;
        a_in = a;
        b_in = b;
        step();
        for (int i = 0; i < N; i++) begin
            check("run_no_done", {15'b0, done_valid}, 0);
            check("run_not_ready", {15'b0, start_ready}, 0);
            start_valid = 1'($urandom_range(0, 1));
            a_in = N'($urandom);
            b_in = N'($urandom);
            step();
        end
        start_valid = chain;
        if (chain) begin
            a_in = na;
            b_in = nb;
        end
        check("done_valid_at_N", {15'b0, done_valid}, 1);
        check("product", product, exp);
        check("busy_done", {15'b0, busy}, 1);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_done_valid", {15'b0, done_valid}, 1);
            check("hold_product", product, exp);
            check("hold_not_ready", {15'b0, start_ready}, 0);
        end
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        check("after_hs_done_valid", {15'b0, done_valid}, 0);
        check("after_hs_start_ready", {15'b0, start_ready}, 1);
        check("after_hs_product_kept", product, exp);
        $display("op %0d * %0d expected %0d got %0d", a, b, exp, product);
    endtask

    initial begin
        #1;
        check("rst_start_ready", {15'b0, start_ready}, 1);
        check("rst_done_valid", {15'b0, done_valid}, 0);
        check("rst_busy", {15'b0, busy}, 0);
        check("rst_product", product, 0);
        #13;
        rst_n = 1'b1;
        step();

        // done_ready high while idle has no effect
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        check("idle_done_ready_ignored", {15'b0, done_valid}, 0);

        run_op(8'd13, 8'd11, 0, 1'b0, '0, '0);
        run_op(8'd255, 8'd255, 0, 1'b0, '0, '0);
        run_op(8'd0, 8'd200, 1, 1'b0, '0, '0);
        run_op(8'd200, 8'd0, 0, 1'b0, '0, '0);
        run_op(8'd12, 8'd12, 3, 1'b1, 8'd7, 8'd9);
        run_op(8'd7, 8'd9, 0, 1'b0, '0, '0);

        // Reset in RUN cycle 4 aborts the operation
        start_valid = 1'b1;
        a_in = 8'd99;
        b_in = 8'd77;
        step();
        start_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("abort_start_ready", {15'b0, start_ready}, 1);
        check("abort_done_valid", {15'b0, done_valid}, 0);
        check("abort_busy", {15'b0, busy}, 0);
        check("abort_product", product, 0);
        repeat (2) step();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            step();
            check("post_abort_no_done", {15'b0, done_valid}, 0);
        end
        run_op(8'd3, 8'd5, 0, 1'b0, '0, '0);

        for (int k = 0; k < 20; k++) begin
            run_op(N'($urandom), N'($urandom), $urandom_range(0, 2), 1'b0, '0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
